// File: rtl/pc_gen.sv
// Program counter generator: sequential fetch, trap/jump/branch redirects, and a
// single pending-redirect slot that holds a redirect requested while fetch is stalled.
module pc_gen #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_en,
  input  logic [31:0] branch_target,
  input  logic        jump_en,
  input  logic [31:0] jump_target,
  input  logic        trap_en,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        pc_valid,
  output logic        redirect_pending,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  // Encoding order is the redirect priority, so a plain compare ranks requests.
  typedef enum logic [1:0] {
    REQ_NONE   = 2'd0,
    REQ_BRANCH = 2'd1,
    REQ_JUMP   = 2'd2,
    REQ_TRAP   = 2'd3
  } req_t;

  req_t        pend_prio;
  logic [31:0] pend_tgt;
  req_t        new_prio;
  logic [31:0] new_tgt;
  req_t        sel_prio;
  logic [31:0] sel_tgt;
  logic        take_new;
  logic        advance;

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    new_prio = REQ_NONE;
    new_tgt  = branch_target;
    if (trap_en) begin
      new_prio = REQ_TRAP;
      new_tgt  = TRAP_VECTOR;
    end else if (jump_en) begin
      new_prio = REQ_JUMP;
      new_tgt  = jump_target;
    end else if (branch_en) begin
      new_prio = REQ_BRANCH;
      new_tgt  = branch_target;
    end
    take_new = (new_prio != REQ_NONE) && (new_prio >= pend_prio);
    sel_prio = take_new ? new_prio : pend_prio;
    sel_tgt  = take_new ? new_tgt  : pend_tgt;
    // The first cycle after reset release presents RESET_PC and behaves like a stall.
    advance  = pc_valid && !stall;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc               <= RESET_PC;
      pc_valid         <= 1'b0;
      pend_prio        <= REQ_NONE;
      pend_tgt         <= 32'd0;
      redirect_pending <= 1'b0;
      misalign_err     <= 1'b0;
      fetch_count      <= 32'd0;
    end else begin
      pc_valid     <= 1'b1;
      misalign_err <= 1'b0;
      if (advance) begin
        fetch_count      <= fetch_count + 32'd1;
        pend_prio        <= REQ_NONE;
        redirect_pending <= 1'b0;
        if (sel_prio != REQ_NONE) begin
          pc           <= {sel_tgt[31:2], 2'b00};
          misalign_err <= |sel_tgt[1:0];
        end else begin
          pc <= pc_plus4;
        end
      end else if (take_new) begin
        pend_prio        <= new_prio;
        pend_tgt         <= new_tgt;
        redirect_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios followed by randomized traffic, each cycle
// compared against a reference model built from the redirect/stall rules.
module tb_pc_gen;

  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_en;
  logic [31:0] branch_target;
  logic        jump_en;
  logic [31:0] jump_target;
  logic        trap_en;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pc_valid;
  logic        redirect_pending;
  logic        misalign_err;
  logic [31:0] fetch_count;

  int tests = 0;
  int fails = 0;

  // Reference state: pending slot as (priority rank, raw target); rank 0 = empty.
  logic [31:0] m_pc;
  logic        m_valid;
  int          m_prank;
  logic [31:0] m_ptgt;
  logic        m_mis;
  logic [31:0] m_cnt;

  pc_gen #(.RESET_PC(RESET_PC), .TRAP_VECTOR(TRAP_VECTOR)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_en(branch_en), .branch_target(branch_target),
    .jump_en(jump_en), .jump_target(jump_target), .trap_en(trap_en),
    .pc(pc), .pc_plus4(pc_plus4), .pc_valid(pc_valid),
    .redirect_pending(redirect_pending), .misalign_err(misalign_err),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_step(input logic rst, input logic st, input logic b, input logic [31:0] bt,
                            input logic j, input logic [31:0] jt, input logic t);
    int rank;
    logic [31:0] tgt;
    if (!rst) begin
      m_pc = RESET_PC; m_valid = 0; m_prank = 0; m_ptgt = 0; m_mis = 0; m_cnt = 0;
      return;
    end
    rank = t ? 3 : (j ? 2 : (b ? 1 : 0));
    tgt  = t ? TRAP_VECTOR : (j ? jt : bt);
    m_mis = 0;
    if (!m_valid || st) begin
      if (rank != 0 && rank >= m_prank) begin
        m_prank = rank;
        m_ptgt  = tgt;
      end
      m_valid = 1;
    end else begin
      if (m_prank != 0 && rank < m_prank) begin
        rank = m_prank;
        tgt  = m_ptgt;
      end
      if (rank != 0) begin
        m_pc  = tgt & 32'hFFFF_FFFC;
        m_mis = (tgt[1:0] != 2'b00);
      end else begin
        m_pc = m_pc + 32'd4;
      end
      m_prank = 0;
      m_cnt   = m_cnt + 32'd1;
    end
  endtask

  // Called 1 time unit after a posedge: drive, clock once, update model, compare.
  task automatic cyc(input logic rst, input logic st, input logic b, input logic [31:0] bt,
                     input logic j, input logic [31:0] jt, input logic t);
    reset = rst; stall = st; branch_en = b; branch_target = bt;
    jump_en = j; jump_target = jt; trap_en = t;
    @(posedge clk);
    model_step(rst, st, b, bt, j, jt, t);
    #1;
    chk("pc", pc, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("pc_valid", {31'd0, pc_valid}, {31'd0, m_valid});
    chk("redirect_pending", {31'd0, redirect_pending}, {31'd0, m_prank != 0});
    chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
    chk("fetch_count", fetch_count, m_cnt);
  endtask

  task automatic idle();
    cyc(1, 0, 0, 32'd0, 0, 32'd0, 0);
  endtask

  initial begin
    logic [31:0] rb, rj;
    reset = 0; stall = 0; branch_en = 0; branch_target = 0;
    jump_en = 0; jump_target = 0; trap_en = 0;
    m_pc = RESET_PC; m_valid = 0; m_prank = 0; m_ptgt = 0; m_mis = 0; m_cnt = 0;
    @(posedge clk); #1;

    // Reset for two cycles, then free-running fetch.
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 32'h40, 1, 32'h80, 1);
    chk("reset_pc", pc, RESET_PC);
    idle();
    chk("first_pc_valid", {31'd0, pc_valid}, 32'd1);
    chk("first_pc_hold", pc, 32'h0);
    idle(); chk("seq_pc4", pc, 32'h4);
    idle(); chk("seq_pc8", pc, 32'h8);
    idle(); chk("seq_pcC", pc, 32'hC); chk("seq_cnt3", fetch_count, 32'd3);
    idle(); chk("seq_pc10", pc, 32'h10);

    // Jump beats branch in the same cycle.
    cyc(1, 0, 1, 32'h80, 1, 32'h40, 0); chk("prio_jump", pc, 32'h40);
    idle(); chk("after_jump", pc, 32'h44);

    // Stalled redirects: jump replaces the earlier branch in the slot.
    cyc(1, 0, 0, 0, 1, 32'h20, 0); chk("to_20", pc, 32'h20);
    cyc(1, 1, 1, 32'h200, 0, 0, 0);
    cyc(1, 1, 0, 0, 1, 32'h300, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("stall_hold", pc, 32'h20); chk("pend_set", {31'd0, redirect_pending}, 32'd1);
    idle(); chk("pend_apply", pc, 32'h300); chk("pend_clr", {31'd0, redirect_pending}, 32'd0);

    // Misaligned jump target.
    cyc(1, 0, 0, 0, 1, 32'h106, 0); chk("mis_pc", pc, 32'h104);
    chk("mis_pulse", {31'd0, misalign_err}, 32'd1);
    idle(); chk("mis_clear", {31'd0, misalign_err}, 32'd0);

    // Pending trap discarded by reset.
    cyc(1, 1, 0, 0, 0, 0, 1);
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("rst_pend", {31'd0, redirect_pending}, 32'd0);
    idle(); idle(); chk("no_trap", pc, 32'h4);

    // Wrap at top of address space.
    cyc(1, 0, 0, 0, 1, 32'hFFFF_FFFC, 0); chk("top_pc", pc, 32'hFFFF_FFFC);
    idle(); chk("wrap_pc", pc, 32'h0); chk("wrap_plus4", pc_plus4, 32'h4);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      rb = $urandom; rj = $urandom;
      if ($urandom_range(0, 3) == 0) rb[1:0] = 2'b00;
      cyc(($urandom_range(0, 60) != 0), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 3) == 0), rb, ($urandom_range(0, 4) == 0), rj,
          ($urandom_range(0, 9) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset; bits [1:0] SHALL be 0.
REQ-002 Parameter TRAP_VECTOR, default 32'h0000_0100: PC loaded on trap redirect; bits [1:0] SHALL be 0.
REQ-003 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-004 reset  input  1  synchronous, active-low reset; SHALL take effect only at a posedge clk while low.
REQ-005 stall  input  1  1 = hold PC; downstream fetch cannot accept a new address.
REQ-006 branch_en  input  1  taken-branch redirect request, valid in the current cycle only.
REQ-007 branch_target  input  32  branch destination address.
REQ-008 jump_en  input  1  jump redirect request, valid in the current cycle only.
REQ-009 jump_target  input  32  jump destination address.
REQ-010 trap_en  input  1  trap redirect request to TRAP_VECTOR, valid in the current cycle only.
REQ-011 pc  output  32  registered fetch address; drives the instruction ROM PC input.
REQ-012 pc_plus4  output  32  combinational pc + 4, mod 2^32.
REQ-013 pc_valid  output  1  registered; 1 = pc is a live fetch address.
REQ-014 redirect_pending  output  1  registered; 1 = redirect latched during stall, not yet applied.
REQ-015 misalign_err  output  1  registered one-cycle pulse; an applied target had bits [1:0] != 0.
REQ-016 fetch_count  output  32  registered count of PC advances/redirects since reset.

Function
REQ-017 Request priority SHALL be trap > jump > branch; within one cycle only the highest asserted request is considered.
REQ-018 Unstalled cycle, no request, no pending: pc SHALL become pc + 4, wrapping from 32'hFFFF_FFFC to 32'h0000_0000.
REQ-019 Unstalled cycle with a new request and no pending: pc SHALL become the selected target with bits [1:0] forced to 0, one cycle after the request (no sequential pc + 4 that cycle).
REQ-020 Stalled cycle: pc, pc_valid and fetch_count SHALL hold their values.
REQ-021 Stalled cycle with a request: the target and its priority SHALL be latched into a pending slot and redirect_pending SHALL be 1 from the next cycle.
REQ-022 Further requests while pending: a request of equal or higher priority SHALL replace the slot; a lower-priority request SHALL be discarded.
REQ-023 First unstalled cycle with pending set: pc SHALL load the pending target, or the new request if one is present of equal or higher priority; redirect_pending SHALL clear in the same update.
REQ-024 The pending slot SHALL be applied on the first unstalled cycle, never earlier; stall held indefinitely SHALL hold it indefinitely.
REQ-025 misalign_err SHALL be 1 for exactly the cycle after a target with bits [1:0] != 0 is applied to pc; it SHALL NOT fire on latching into the pending slot.
REQ-026 fetch_count SHALL increment by 1 on every unstalled cycle after reset and wrap from 32'hFFFF_FFFF to 0.
REQ-027 pc_valid SHALL be 1 from the first posedge after reset goes high and SHALL remain 1; stall does not clear it.

Reset
REQ-028 At any posedge with reset low: pc = RESET_PC, pc_valid = 0, redirect_pending = 0, pending slot cleared, misalign_err = 0, fetch_count = 0.
REQ-029 Reset SHALL override stall and all requests in the same cycle; a pending redirect SHALL be discarded by reset.
REQ-030 The first cycle after reset release SHALL present pc = RESET_PC with pc_valid = 1; pc advances on the following unstalled edge.

Verification
REQ-031 Reset low for 2 cycles, then high, no stall -> pc sequence 0x0, 0x4, 0x8, 0xC; fetch_count 0, 1, 2, 3; pc_valid 0 then 1.
REQ-032 At pc = 0x10, assert branch_en and jump_en together (branch_target 0x80, jump_target 0x40) -> next pc = 0x40, then 0x44.
REQ-033 stall = 1 for 3 cycles at pc = 0x20; branch 0x200 in stall cycle 1, jump 0x300 in stall cycle 2 -> pc stays 0x20, redirect_pending = 1; after stall drops -> pc = 0x300, redirect_pending = 0.
REQ-034 jump_target 0x00000106 while unstalled -> pc = 0x104 and misalign_err = 1 for one cycle only.
REQ-035 Pending trap latched under stall, reset driven low before unstall -> pc = RESET_PC, redirect_pending = 0, and no trap redirect after release.
REQ-036 Force pc to 0xFFFFFFFC via jump, no stall -> next pc = 0x00000000, pc_plus4 = 0x00000004.
